// File: rtl/rc4_ksa_param.sv
// rtl/rc4_ksa_param.sv - parametrised RC4 key-scheduling engine with optional identity fill
//
// Runs an optional FILL pass (S[k] = k), then the RC4 KSA swap loop over all
// 2^ADDR_W entries of an external single-port S-memory.
// Memory read latency is one cycle: the address presented in cycle c gives q in c+1.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   start       run request, accepted only in IDLE or DONE
//   do_init     sampled with start: 1 = FILL phase first
//   secret_key  key, byte 0 in the most significant byte, latched at acceptance
//   address     S-memory address
//   data        S-memory write data
//   wren        S-memory write enable
//   q           S-memory read data
//   busy        high during FILL and swap cycles (memory-port mux select)
//   done        high in DONE until the next accepted start or reset
module rc4_ksa_param #(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   do_init,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [ADDR_W-1:0]      address,
    output logic [ADDR_W-1:0]      data,
    output logic                   wren,
    input  logic [ADDR_W-1:0]      q,
    output logic                   busy,
    output logic                   done
);

    localparam int              KX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KX_W-1:0] KX_LAST = KX_W'(KEY_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, FILL, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE
    } state_t;

    state_t                 state, state_next;
    logic [8*KEY_BYTES-1:0] key_r;
    logic [ADDR_W-1:0]      i, j, si, sj;
    logic [ADDR_W-1:0]      key_lo;
    logic [KX_W-1:0]        kx;
    logic                   last_i;

    assign last_i = (i == '1);

    // Key byte kx sits at the MSB end for kx = 0; only its low ADDR_W bits matter
    // because j is computed mod 2^ADDR_W.
    assign key_lo = ADDR_W'(key_r >> (8 * (KEY_BYTES - 1 - int'(kx))));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            key_r <= '0;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            kx    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_r <= secret_key;
                        i     <= '0;
                        j     <= '0;
                        kx    <= '0;
                    end
                end
                // i doubles as the fill counter; it wraps back to 0 after N-1,
                // which is exactly the starting index of the swap loop.
                FILL: i <= i + ADDR_W'(1);
                GET_I: begin
                    si <= q;
                    j  <= j + q + key_lo;
                end
                GET_J: sj <= q;
                WR_J: begin
                    i  <= i + ADDR_W'(1);
                    kx <= (kx == KX_LAST) ? '0 : kx + KX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = do_init ? FILL : RD_I;
            FILL:       if (last_i) state_next = RD_I;
            RD_I:       state_next = GET_I;
            GET_I:      state_next = RD_J;
            RD_J:       state_next = GET_J;
            GET_J:      state_next = WR_I;
            WR_I:       state_next = WR_J;
            WR_J:       state_next = last_i ? DONE : RD_I;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        address = '0;
        data    = '0;
        wren    = 1'b0;
        busy    = (state != IDLE) && (state != DONE);
        done    = (state == DONE);
        case (state)
            FILL: begin
                address = i;
                data    = i;
                wren    = 1'b1;
            end
            RD_I: address = i;
            RD_J: address = j;
            WR_I: begin
                address = i;
                data    = sj;
                wren    = 1'b1;
            end
            // When i == j this overwrites the WR_I value with si, which equals sj.
            WR_J: begin
                address = j;
                data    = si;
                wren    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_ksa_param.sv
// tb/tb_rc4_ksa_param.sv - self-checking bench for rc4_ksa_param against an RC4 KSA reference model
module tb_rc4_ksa_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 256-entry, 3-byte key instance
    logic        start8, init8, wren8, busy8, done8;
    logic [23:0] key8;
    logic [7:0]  addr8, data8, q8;
    logic [7:0]  mem8 [256];

    // 4-entry, 1-byte key instance
    logic        start21, init21, wren21, busy21, done21;
    logic [7:0]  key21;
    logic [1:0]  addr21, data21, q21;
    logic [1:0]  mem21 [4];

    // 4-entry, 2-byte key instance with preloadable memory
    logic        start22, init22, wren22, busy22, done22, load22;
    logic [15:0] key22;
    logic [1:0]  addr22, data22, q22;
    logic [1:0]  mem22 [4];

    int checks = 0;
    int fails  = 0;
    int ref_s [256];

    rc4_ksa_param #(.KEY_BYTES(3), .ADDR_W(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .do_init(init8), .secret_key(key8),
        .address(addr8), .data(data8), .wren(wren8), .q(q8), .busy(busy8), .done(done8)
    );
    rc4_ksa_param #(.KEY_BYTES(1), .ADDR_W(2)) u21 (
        .clk(clk), .reset(reset), .start(start21), .do_init(init21), .secret_key(key21),
        .address(addr21), .data(data21), .wren(wren21), .q(q21), .busy(busy21), .done(done21)
    );
    rc4_ksa_param #(.KEY_BYTES(2), .ADDR_W(2)) u22 (
        .clk(clk), .reset(reset), .start(start22), .do_init(init22), .secret_key(key22),
        .address(addr22), .data(data22), .wren(wren22), .q(q22), .busy(busy22), .done(done22)
    );

    always @(posedge clk) begin
        q8 <= mem8[addr8];
        if (wren8) mem8[addr8] <= data8;
    end
    always @(posedge clk) begin
        q21 <= mem21[addr21];
        if (wren21) mem21[addr21] <= data21;
    end
    always @(posedge clk) begin
        q22 <= mem22[addr22];
        if (load22) begin
            for (int k = 0; k < 4; k++) mem22[k] <= 2'(k);
        end else if (wren22) begin
            mem22[addr22] <= data22;
        end
    end

    // Textbook RC4 KSA on ref_s over n entries, key bytes reduced mod n.
    task automatic ref_ksa(input int n, input int kb, input logic [255:0] key);
        int jj = 0;
        int t;
        int kbyte;
        for (int ii = 0; ii < n; ii++) begin
            kbyte = int'(key[8*(kb-1-(ii % kb)) +: 8]);
            jj = (jj + ref_s[ii] + (kbyte % n)) % n;
            t = ref_s[ii];
            ref_s[ii] = ref_s[jj];
            ref_s[jj] = t;
        end
    endtask

    task automatic ref_identity(input int n);
        for (int k = 0; k < n; k++) ref_s[k] = k;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start8 = 0; init8 = 0; key8 = '0;
        start21 = 0; init21 = 0; key21 = '0;
        start22 = 0; init22 = 0; key22 = '0; load22 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({addr8, data8, wren8, busy8, done8} !== 19'd0) begin
                fails++;
                $display("FAIL reset_idle_a8 cycle %0d: addr=%0d data=%0d wren=%0b busy=%0b done=%0b, want all 0",
                         c, addr8, data8, wren8, busy8, done8);
            end
            checks++;
            if ({addr21, data21, wren21, busy21, done21, addr22, data22, wren22, busy22, done22} !== 14'd0) begin
                fails++;
                $display("FAIL reset_idle_a2 cycle %0d: u21 addr=%0d wren=%0b busy=%0b done=%0b u22 addr=%0d wren=%0b busy=%0b done=%0b, want all 0",
                         c, addr21, wren21, busy21, done21, addr22, wren22, busy22, done22);
            end
        end
    endtask

    task automatic test_fill_timing;
        int  nw = 0;
        logic exp_wren;
        @(negedge clk);
        key8 = 24'h000000; init8 = 1'b1; start8 = 1'b1;
        for (int n = 1; n <= 1795; n++) begin
            @(negedge clk);
            if (n == 1) start8 = 1'b0;
            exp_wren = (n <= 256) || (n > 256 && n <= 1792 && ((n - 257) % 6) >= 4);
            if (wren8) nw++;
            checks++;
            if ({busy8, done8, wren8} !== {1'(n <= 1792), 1'(n >= 1793), exp_wren}) begin
                fails++;
                $display("FAIL fill_timing cycle %0d: busy=%0b done=%0b wren=%0b, want busy=%0b done=%0b wren=%0b",
                         n, busy8, done8, wren8, n <= 1792, n >= 1793, exp_wren);
            end
            if (n <= 256) begin
                checks++;
                if (addr8 !== 8'(n - 1) || data8 !== 8'(n - 1)) begin
                    fails++;
                    $display("FAIL fill_write cycle %0d: addr=%0d data=%0d, want %0d", n, addr8, data8, n - 1);
                end
            end
            // i=2 with a zero key: j = 0+0 -> 0+1 -> 1+2 = 3, so S[2]<-3 then S[3]<-2
            if (n == 273 || n == 274) begin
                checks++;
                if (addr8 !== ((n == 273) ? 8'd2 : 8'd3) || data8 !== ((n == 273) ? 8'd3 : 8'd2)) begin
                    fails++;
                    $display("FAIL swap_i2 cycle %0d: addr=%0d data=%0d, want addr=%0d data=%0d",
                             n, addr8, data8, (n == 273) ? 2 : 3, (n == 273) ? 3 : 2);
                end
            end
        end
        checks++;
        if (nw !== 768) begin
            fails++;
            $display("FAIL fill_wren_count: got %0d write cycles, want 768", nw);
        end
        ref_identity(256);
        ref_ksa(256, 3, 256'h0);
        for (int k = 0; k < 256; k++) begin
            checks++;
            if (int'(mem8[k]) !== ref_s[k]) begin
                fails++;
                $display("FAIL zero_key_mem[%0d]: got %0d, want %0d", k, mem8[k], ref_s[k]);
            end
        end
    endtask

    task automatic test_small_init;
        int exp21 [4] = '{0, 2, 3, 1};
        @(negedge clk);
        key21 = 8'h01; init21 = 1'b1; start21 = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            @(negedge clk);
            if (n == 1) start21 = 1'b0;
            checks++;
            if ({busy21, done21} !== {1'(n <= 28), 1'(n >= 29)}) begin
                fails++;
                $display("FAIL small_init_timing cycle %0d: busy=%0b done=%0b, want busy=%0b done=%0b",
                         n, busy21, done21, n <= 28, n >= 29);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (int'(mem21[k]) !== exp21[k]) begin
                fails++;
                $display("FAIL small_init_mem[%0d]: got %0d, want %0d", k, mem21[k], exp21[k]);
            end
        end
    endtask

    task automatic test_restart_from_done;
        logic [7:0] k = 8'($urandom);
        checks++;
        if (done21 !== 1'b1) begin
            fails++;
            $display("FAIL restart_pre_done: done=%0b, want 1", done21);
        end
        key21 = k; init21 = 1'b1; start21 = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start21 = 1'b0;
                checks++;
                if ({busy21, done21} !== 2'b10) begin
                    fails++;
                    $display("FAIL restart_edge: busy=%0b done=%0b, want busy=1 done=0", busy21, done21);
                end
            end
            if (n == 29) begin
                checks++;
                if ({busy21, done21} !== 2'b01) begin
                    fails++;
                    $display("FAIL restart_done: busy=%0b done=%0b, want busy=0 done=1", busy21, done21);
                end
            end
        end
        ref_identity(4);
        ref_ksa(4, 1, {248'h0, k});
        for (int a = 0; a < 4; a++) begin
            checks++;
            if (int'(mem21[a]) !== ref_s[a]) begin
                fails++;
                $display("FAIL restart_mem[%0d] key=%02h: got %0d, want %0d", a, k, mem21[a], ref_s[a]);
            end
        end
    endtask

    task automatic test_preload_swap;
        int stage [4][4] = '{'{3, 1, 2, 0}, '{1, 3, 2, 0}, '{1, 2, 3, 0}, '{1, 0, 3, 2}};
        int nw = 0;
        @(negedge clk) load22 = 1'b1;
        @(negedge clk) load22 = 1'b0;
        key22 = 16'h0300; init22 = 1'b0; start22 = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            if (n == 1) start22 = 1'b0;
            if (wren22) nw++;
            checks++;
            if ({busy22, done22} !== {1'(n <= 24), 1'(n >= 25)}) begin
                fails++;
                $display("FAIL preload_timing cycle %0d: busy=%0b done=%0b, want busy=%0b done=%0b",
                         n, busy22, done22, n <= 24, n >= 25);
            end
            if (n > 1 && (n - 1) % 6 == 0 && n <= 25) begin
                for (int a = 0; a < 4; a++) begin
                    checks++;
                    if (int'(mem22[a]) !== stage[(n - 1) / 6 - 1][a]) begin
                        fails++;
                        $display("FAIL preload_stage i=%0d mem[%0d]: got %0d, want %0d",
                                 (n - 1) / 6 - 1, a, mem22[a], stage[(n - 1) / 6 - 1][a]);
                    end
                end
            end
        end
        checks++;
        if (nw !== 8) begin
            fails++;
            $display("FAIL preload_wren_count: got %0d, want 8", nw);
        end
    endtask

    task automatic test_random_keys;
        for (int r = 0; r < 3; r++) begin
            logic [23:0] k = (r == 0) ? 24'h000249 : 24'($urandom);
            @(negedge clk);
            key8 = k; init8 = 1'b1; start8 = 1'b1;
            for (int n = 1; n <= 1793; n++) begin
                @(negedge clk);
                if (n == 1792 || n == 1793) begin
                    checks++;
                    if ({busy8, done8} !== ((n == 1792) ? 2'b10 : 2'b01)) begin
                        fails++;
                        $display("FAIL rand_timing key=%06h cycle %0d: busy=%0b done=%0b", k, n, busy8, done8);
                    end
                end
                if (n <= 1792) begin
                    start8 = 1'($urandom);
                    init8  = 1'($urandom);
                    key8   = 24'($urandom);
                end else begin
                    start8 = 1'b0;
                end
            end
            ref_identity(256);
            ref_ksa(256, 3, {232'h0, k});
            for (int a = 0; a < 256; a++) begin
                checks++;
                if (int'(mem8[a]) !== ref_s[a]) begin
                    fails++;
                    $display("FAIL rand_mem key=%06h [%0d]: got %0d, want %0d", k, a, mem8[a], ref_s[a]);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        int nw = 0;
        @(negedge clk);
        key8 = 24'($urandom); init8 = 1'b1; start8 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start8 = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({addr8, data8, wren8, busy8, done8} !== 19'd0) begin
            fails++;
            $display("FAIL mid_reset: addr=%0d data=%0d wren=%0b busy=%0b done=%0b, want all 0",
                     addr8, data8, wren8, busy8, done8);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wren8 || busy8 || done8) nw++;
        end
        checks++;
        if (nw !== 0) begin
            fails++;
            $display("FAIL mid_reset_quiet: %0d active cycles after reset, want 0", nw);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_fill_timing();
        test_small_init();
        test_restart_from_done();
        test_preload_swap();
        test_random_keys();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
